// File: rtl/pipe_issue.sv
// In-order issue unit: instruction FIFO feeding the ALU pipeline with RAW interlock.
// Define PIPE_ISSUE_HAZARD_EN to build the scoreboard, interlock and stall counter.
module pipe_issue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PIPE_LAT = 3
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_instr,
    output logic [3:0]  rs1,
    output logic [3:0]  rs2,
    output logic [3:0]  rd,
    output logic [3:0]  func,
    output logic [7:0]  addr,
    output logic        issue_valid,
    output logic [15:0] stall_count,
    output logic        busy
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pipe_issue: DEPTH must be a power of two >= 2");
    end
    if (PIPE_LAT < 1) begin : g_bad_lat
        $error("pipe_issue: PIPE_LAT must be >= 1");
    end

    logic [23:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          empty, full, push, pop, hazard;
    logic [23:0]   head;

    logic [3:0]    rs1_q, rs2_q, rd_q, func_q;
    logic [3:0]    rs1_d, rs2_d, rd_d, func_d;
    logic [7:0]    addr_q, addr_d;
    logic          issue_valid_q;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW + 1)'(DEPTH));
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q];
    assign pop      = !empty && !hazard;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        func_d = func_q;
        rd_d   = rd_q;
        rs1_d  = rs1_q;
        rs2_d  = rs2_q;
        addr_d = addr_q;
        if (pop) begin
            func_d = head[23:20];
            rd_d   = head[19:16];
            rs1_d  = head[15:12];
            rs2_d  = head[11:8];
            addr_d = head[7:0];
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            func_q        <= '0;
            rd_q          <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            addr_q        <= '0;
            issue_valid_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q       <= count_d;
            func_q        <= func_d;
            rd_q          <= rd_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            addr_q        <= addr_d;
            issue_valid_q <= pop;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk1) begin
        if (push) mem_q[wr_ptr_q] <= in_instr;
    end

`ifdef PIPE_ISSUE_HAZARD_EN
    logic [PIPE_LAT-1:0] sb_valid_q;
    logic [3:0]          sb_rd_q [PIPE_LAT];
    logic [15:0]         stall_q;

    always_comb begin
        hazard = 1'b0;
        for (int unsigned k = 0; k < PIPE_LAT; k++) begin
            if (sb_valid_q[k] && (sb_rd_q[k] == head[15:12] || sb_rd_q[k] == head[11:8])) begin
                hazard = 1'b1;
            end
        end
    end

    // Entry k holds an rd issued k+1 edges ago; it drops out once written back.
    always_ff @(posedge clk1) begin
        if (rst) begin
            sb_valid_q <= '0;
            for (int unsigned k = 0; k < PIPE_LAT; k++) sb_rd_q[k] <= '0;
            stall_q    <= '0;
        end else begin
            sb_valid_q[0] <= pop;
            sb_rd_q[0]    <= rd_d;
            for (int unsigned k = 1; k < PIPE_LAT; k++) begin
                sb_valid_q[k] <= sb_valid_q[k-1];
                sb_rd_q[k]    <= sb_rd_q[k-1];
            end
            if (!empty && hazard && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_count = stall_q;
    assign busy        = !empty || (|sb_valid_q);
`else
    assign hazard      = 1'b0;
    assign stall_count = '0;
    assign busy        = !empty;
`endif

    assign func        = func_q;
    assign rd          = rd_q;
    assign rs1         = rs1_q;
    assign rs2         = rs2_q;
    assign addr        = addr_q;
    assign issue_valid = issue_valid_q;

endmodule

// File: tb/tb_pipe_issue.sv
// Directed bench for pipe_issue; expectations follow PIPE_ISSUE_HAZARD_EN when defined.
module tb_pipe_issue;
    localparam int unsigned LAT = 3;
`ifdef PIPE_ISSUE_HAZARD_EN
    localparam bit HAZ = 1'b1;
`else
    localparam bit HAZ = 1'b0;
`endif
    localparam logic [3:0] F_ADD = 4'h0, F_SUB = 4'h1, F_MLA = 4'h2, F_SLA = 4'h3;

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [23:0] in_instr = '0;
    logic        in_ready, issue_valid, busy;
    logic [3:0]  rs1, rs2, rd, func;
    logic [7:0]  addr;
    logic [15:0] stall_count;

    pipe_issue #(.DEPTH(4), .PIPE_LAT(LAT)) dut (
        .clk1       (clk1),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .func       (func),
        .addr       (addr),
        .issue_valid(issue_valid),
        .stall_count(stall_count),
        .busy       (busy)
    );

    always #5 clk1 = ~clk1;

    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    logic [23:0] log_instr [$];
    int          log_cyc [$];
    always @(negedge clk1) begin
        if (issue_valid) begin
            log_instr.push_back({func, rd, rs1, rs2, addr});
            log_cyc.push_back(cyc);
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] mk(input logic [3:0] f, input logic [3:0] d,
                                       input logic [3:0] s1, input logic [3:0] s2,
                                       input logic [7:0] a);
        return {f, d, s1, s2, a};
    endfunction

    function automatic logic [31:0] got_instr(input int i);
        return (i < log_instr.size()) ? {8'h0, log_instr[i]} : 32'hDEAD_BEEF;
    endfunction

    function automatic int got_cyc(input int i);
        return (i < log_cyc.size()) ? log_cyc[i] : -1000;
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk1);
            #1;
        end
    endtask

    task automatic push(input logic [23:0] ins);
        int   budget;
        logic ok;
        budget   = 50;
        in_valid = 1'b1;
        in_instr = ins;
        do begin
            ok = in_ready;
            step();
            budget--;
        end while (!ok && budget > 0);
        in_valid = 1'b0;
        if (!ok) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        #1;
        log_instr.delete();
        log_cyc.delete();
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_fields"}, {8'h0, func, rd, rs1, rs2, addr}, 32'd0);
        check({pfx, "_iv"}, {31'd0, issue_valid}, 32'd0);
        check({pfx, "_stall"}, {16'd0, stall_count}, 32'd0);
        check({pfx, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    logic [23:0] p, s, a2, v[5];

    initial begin
        // Power-on reset.
        step(2);
        check_zero("por");
        check("por_ready_in_rst", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("por_ready_after", {31'd0, in_ready}, 32'd1);

        // Reset mid-operation with queued instructions.
        p = mk(F_ADD, 4'd10, 4'd3, 4'd5, 8'd1);
        push(p);
        push(mk(F_SUB, 4'd14, 4'd10, 4'd5, 8'd2));
        push(mk(F_SUB, 4'd13, 4'd10, 4'd5, 8'd3));
        push(mk(F_SUB, 4'd12, 4'd10, 4'd5, 8'd4));
        check("mid_stall", {16'd0, stall_count}, HAZ ? 32'd2 : 32'd0);
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step(1);
        check_zero("rst1");
        check("rst1_ready", {31'd0, in_ready}, 32'd0);
        step(1);
        check_zero("rst2");
        rst = 1'b0;
        #1;
        check("rst_ready_after", {31'd0, in_ready}, 32'd1);
        step(10);
        check("rst_no_drop_issue", log_instr.size(), HAZ ? 32'd1 : 32'd3);
        check("rst_first", got_instr(0), {8'h0, p});
        check("rst_idle_busy", {31'd0, busy}, 32'd0);

        // Independent stream issues back-to-back.
        do_reset();
        p  = mk(F_ADD, 4'd10, 4'd3, 4'd5, 8'd125);
        s  = mk(F_MLA, 4'd12, 4'd3, 4'd8, 8'd126);
        a2 = mk(F_SLA, 4'd13, 4'd7, 4'd3, 8'd127);
        push(p);
        push(s);
        push(a2);
        step(10);
        check("ind_count", log_instr.size(), 32'd3);
        check("ind_add", got_instr(0), {8'h0, p});
        check("ind_mla", got_instr(1), {8'h0, s});
        check("ind_sla", got_instr(2), {8'h0, a2});
        check("ind_gap1", got_cyc(1) - got_cyc(0), 32'd1);
        check("ind_gap2", got_cyc(2) - got_cyc(1), 32'd1);
        check("ind_stall", {16'd0, stall_count}, 32'd0);
        check("ind_busy", {31'd0, busy}, 32'd0);

        // RAW stall.
        do_reset();
        p = mk(F_ADD, 4'd10, 4'd3, 4'd5, 8'd10);
        s = mk(F_SUB, 4'd14, 4'd10, 4'd5, 8'd11);
        push(p);
        push(s);
        check("raw_busy", {31'd0, busy}, 32'd1);
        step(12);
        check("raw_count", log_instr.size(), 32'd2);
        check("raw_add", got_instr(0), {8'h0, p});
        check("raw_sub", got_instr(1), {8'h0, s});
        check("raw_gap", got_cyc(1) - got_cyc(0), HAZ ? LAT + 1 : 32'd1);
        check("raw_stall", {16'd0, stall_count}, HAZ ? LAT : 32'd0);

        // A hazardous head blocks a younger independent instruction.
        do_reset();
        a2 = mk(F_ADD, 4'd3, 4'd1, 4'd2, 8'd12);
        push(p);
        push(s);
        push(a2);
        step(12);
        check("blk_count", log_instr.size(), 32'd3);
        check("blk_0", got_instr(0), {8'h0, p});
        check("blk_1", got_instr(1), {8'h0, s});
        check("blk_2", got_instr(2), {8'h0, a2});
        check("blk_gap_sub", got_cyc(1) - got_cyc(0), HAZ ? LAT + 1 : 32'd1);
        check("blk_gap_add", got_cyc(2) - got_cyc(1), 32'd1);

        // Fill the FIFO behind a stalled head.
        do_reset();
        for (int i = 0; i < 5; i++) v[i] = mk(F_SUB, 4'(i + 1), 4'd10, 4'd10, 8'(40 + i));
        push(p);
        for (int i = 0; i < 4; i++) push(v[i]);
        check("full_ready", {31'd0, in_ready}, HAZ ? 32'd0 : 32'd1);
        push(v[4]);
        step(15);
        check("full_count", log_instr.size(), 32'd6);
        check("full_p", got_instr(0), {8'h0, p});
        for (int i = 0; i < 5; i++) check($sformatf("full_d%0d", i), got_instr(i + 1), {8'h0, v[i]});
        check("full_stall", {16'd0, stall_count}, HAZ ? LAT : 32'd0);
        check("full_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
